// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART transmitter.
// Holds the FSM state encoding and the parity mode codes seen on cfg_parity.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Mode 2'b11 is reserved and behaves like PAR_NONE.
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_framed_if.sv
// Valid/ready stream carrying one multi-word beat into the UART transmitter.
// The master drives valid and data; the slave returns ready.
interface uart_tx_framed_if #(
    parameter int W_OUT = 24
);
    logic             s_valid;
    logic [W_OUT-1:0] s_data;
    logic             s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: down-counter reloaded from a divisor captured at beat start.
// o_tick is high for the last clock of every line bit while i_run is high.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_div <= i_div;
            r_cnt <= i_div;
        end else if (i_run) begin
            if (r_cnt == '0) begin
                r_cnt <= r_div;
            end else begin
                r_cnt <= r_cnt - DIV_W'(1);
            end
        end
    end

    assign o_tick = i_run && (r_cnt == '0);

endmodule

// File: rtl/uart_tx_framed.sv
// UART transmitter that serialises one W_OUT-bit stream beat as NW back-to-back frames,
// least-significant word first, with optional parity and one or two stop bits.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, s_ready high, waiting for a beat
// START  | start bit (0) of the current word
// DATA   | data bits of the current word, LSB first
// PARITY | parity bit (only when parity enabled for this beat)
// STOP   | stop bit(s) (1); loops back to START while words remain
module uart_tx_framed #(
    parameter int BITS_PER_WORD = 8,
    parameter int W_OUT         = 24,
    parameter int DIV_W         = 16
) (
    input  logic             clk,
    input  logic             rstn,
    uart_tx_framed_if.slave  s_if,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    output logic             tx,
    output logic             busy
);
    import uart_pkg::*;

    localparam int NW   = W_OUT / BITS_PER_WORD;
    localparam int BC_W = $clog2(BITS_PER_WORD);
    localparam int WC_W = (NW > 1) ? $clog2(NW) : 1;

    if ((W_OUT % BITS_PER_WORD) != 0) begin : g_bad_width
        $error("uart_tx_framed: W_OUT must be a multiple of BITS_PER_WORD");
    end
    if ((BITS_PER_WORD < 5) || (BITS_PER_WORD > 9)) begin : g_bad_bits
        $error("uart_tx_framed: BITS_PER_WORD must be within 5..9");
    end

    state_e            r_state;
    logic [W_OUT-1:0]  r_data;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [WC_W-1:0]   r_word_cnt;
    logic              r_stop_cnt;
    logic              r_par;
    logic              r_par_en;
    logic              r_odd;
    logic              r_stop2;
    logic              r_tx;
    logic              r_s_ready;

    state_e            w_state_nxt;
    logic [W_OUT-1:0]  w_data_nxt;
    logic [BC_W-1:0]   w_bit_cnt_nxt;
    logic [WC_W-1:0]   w_word_cnt_nxt;
    logic              w_stop_cnt_nxt;
    logic              w_par_nxt;
    logic              w_tx_nxt;
    logic              w_accept;
    logic              w_tick;
    logic              w_run;

    assign w_accept = (r_state == IDLE) && r_s_ready && s_if.s_valid;
    assign w_run    = (r_state != IDLE);

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk     (clk),
        .rstn    (rstn),
        .i_start (w_accept),
        .i_run   (w_run),
        .i_div   (cfg_div),
        .o_tick  (w_tick)
    );

    // tx is registered from the next-state decode so the line changes on the
    // same edge as the state, keeping every bit exactly one baud period long.
    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_word_cnt_nxt = r_word_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_par_nxt      = r_par;
        w_tx_nxt       = r_tx;

        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt    = START;
                    w_data_nxt     = s_if.s_data;
                    w_word_cnt_nxt = WC_W'(NW - 1);
                    w_tx_nxt       = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt   = DATA;
                    w_bit_cnt_nxt = BC_W'(BITS_PER_WORD - 1);
                    w_par_nxt     = r_odd;
                    w_tx_nxt      = r_data[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_data_nxt = r_data >> 1;
                    w_par_nxt  = r_par ^ r_data[0];
                    if (r_bit_cnt == '0) begin
                        if (r_par_en) begin
                            w_state_nxt = PARITY;
                            w_tx_nxt    = r_par ^ r_data[0];
                        end else begin
                            w_state_nxt    = STOP;
                            w_stop_cnt_nxt = r_stop2;
                            w_tx_nxt       = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - BC_W'(1);
                        w_tx_nxt      = r_data[1];
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_nxt    = STOP;
                    w_stop_cnt_nxt = r_stop2;
                    w_tx_nxt       = 1'b1;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt) begin
                        w_stop_cnt_nxt = 1'b0;
                        w_tx_nxt       = 1'b1;
                    end else if (r_word_cnt != '0) begin
                        w_state_nxt    = START;
                        w_word_cnt_nxt = r_word_cnt - WC_W'(1);
                        w_tx_nxt       = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_stop_cnt <= 1'b0;
            r_par      <= 1'b0;
            r_par_en   <= 1'b0;
            r_odd      <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx       <= 1'b1;
            r_s_ready  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_par      <= w_par_nxt;
            r_tx       <= w_tx_nxt;
            r_s_ready  <= (w_state_nxt == IDLE);
            if (w_accept) begin
                r_par_en <= par_enabled(cfg_parity);
                r_odd    <= (cfg_parity == PAR_ODD);
                r_stop2  <= cfg_stop2;
            end
        end
    end

    assign s_if.s_ready = r_s_ready;
    assign tx           = r_tx;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: line waveform per clock, handshake timing,
// parity, two stop bits, back-to-back beats, config isolation and mid-frame reset.
module tb_uart_tx_framed;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        tx;
    logic        busy;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_q[$];
    logic cap [0:511];

    uart_tx_framed_if #(.W_OUT(24)) s_if ();

    uart_tx_framed #(
        .BITS_PER_WORD (8),
        .W_OUT         (24),
        .DIV_W         (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_if       (s_if),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives the beat so that the next rising edge accepts it; builds the expected line bits.
    task automatic start_beat(input logic [23:0] data, input logic [15:0] div,
                              input logic [1:0] par, input logic st2, input bit keep);
        cfg_div     = div;
        cfg_parity  = par;
        cfg_stop2   = st2;
        s_if.s_data = data;
        s_if.s_valid = 1'b1;
        exp_q.delete();
        for (int w = 0; w < 3; w++) begin
            logic [7:0] wd;
            wd = data[8*w +: 8];
            exp_q.push_back(1'b0);
            for (int b = 0; b < 8; b++) exp_q.push_back(wd[b]);
            if (par == 2'b01) exp_q.push_back(^wd);
            else if (par == 2'b10) exp_q.push_back(~^wd);
            exp_q.push_back(1'b1);
            if (st2) exp_q.push_back(1'b1);
        end
        @(posedge clk);
        #1;
        if (!keep) s_if.s_valid = 1'b0;
    endtask

    task automatic watch(input string tag, input int div, input int n, input int mut_at);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap[k] = tx;
            chk($sformatf("%s_tx[%0d]", tag, k), tx, exp_q[k / (div + 1)]);
            chk($sformatf("%s_ready_low[%0d]", tag, k), s_if.s_ready, 1'b0);
            chk($sformatf("%s_busy[%0d]", tag, k), busy, 1'b1);
            if (k == mut_at) begin
                cfg_div     = 16'd7;
                s_if.s_data = 24'h0F0F0F;
            end
        end
    endtask

    task automatic beat(input string tag, input logic [23:0] data, input logic [15:0] div,
                        input logic [1:0] par, input logic st2, input bit keep,
                        input int clocks, input int mut_at);
        start_beat(data, div, par, st2, keep);
        watch(tag, int'(div), clocks, mut_at);
        @(negedge clk);
        chk({tag, "_end_ready"}, s_if.s_ready, 1'b1);
        chk({tag, "_end_tx"}, tx, 1'b1);
        chk({tag, "_end_busy"}, busy, 1'b0);
    endtask

    function automatic logic [7:0] word_at(input int w, input int len, input int div);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = cap[(w*len + 1 + b) * (div + 1)];
        return v;
    endfunction

    initial begin
        rstn         = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        cfg_div      = 16'd3;
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", s_if.s_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", s_if.s_ready, 1'b1);
        chk("post_rst_tx", tx, 1'b1);

        // 3 words x 10 bits x 4 clocks
        beat("b1", 24'h123456, 16'd3, 2'b00, 1'b0, 1'b0, 120, -1);
        chk("b1_w0", word_at(0, 10, 3), 8'h56);
        chk("b1_w1", word_at(1, 10, 3), 8'h34);
        chk("b1_w2", word_at(2, 10, 3), 8'h12);

        // 11-bit frames, one clock per bit
        beat("even", 24'h000056, 16'd0, 2'b01, 1'b0, 1'b0, 33, -1);
        chk("even_par_w0", cap[9], 1'b0);
        chk("even_stop_w0", cap[10], 1'b1);
        chk("even_start_w1", cap[11], 1'b0);
        chk("even_par_w1", cap[20], 1'b0);

        beat("odd", 24'h000056, 16'd0, 2'b10, 1'b0, 1'b0, 33, -1);
        chk("odd_par_w0", cap[9], 1'b1);
        chk("odd_par_w1", cap[20], 1'b1);

        beat("stop2", 24'hABCDEF, 16'd0, 2'b00, 1'b1, 1'b0, 33, -1);
        chk("stop2_a", cap[9], 1'b1);
        chk("stop2_b", cap[10], 1'b1);
        chk("stop2_c", cap[20], 1'b1);
        chk("stop2_d", cap[21], 1'b1);
        chk("stop2_e", cap[31], 1'b1);
        chk("stop2_f", cap[32], 1'b1);
        chk("stop2_gap", cap[11], 1'b0);
        chk("stop2_w0", word_at(0, 11, 0), 8'hEF);
        chk("stop2_w1", word_at(1, 11, 0), 8'hCD);
        chk("stop2_w2", word_at(2, 11, 0), 8'hAB);

        // s_valid held across two beats: single idle clock at the end check of h0
        beat("h0", 24'h000000, 16'd3, 2'b00, 1'b0, 1'b1, 120, -1);
        beat("hF", 24'hFFFFFF, 16'd3, 2'b00, 1'b0, 1'b0, 120, -1);
        chk("hF_start", cap[0], 1'b0);
        chk("hF_w1", word_at(1, 10, 3), 8'hFF);

        // cfg_div and s_data changed at clock 10 of the beat
        beat("mut", 24'h123456, 16'd3, 2'b00, 1'b0, 1'b0, 120, 10);
        chk("mut_w0", word_at(0, 10, 3), 8'h56);
        chk("mut_w2", word_at(2, 10, 3), 8'h12);
        beat("div8", 24'h0F0F0F, 16'd7, 2'b00, 1'b0, 1'b0, 240, -1);
        chk("div8_w0", word_at(0, 10, 7), 8'h0F);
        chk("div8_bit4", cap[(1 + 4) * 8], 1'b0);

        // reset pulse during data bit 1 of word 1
        start_beat(24'h123456, 16'd3, 2'b00, 1'b0, 1'b0);
        watch("rstmid", 3, 51, -1);
        chk("rstmid_pre_busy", busy, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        chk("rstmid_tx", tx, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_ready", s_if.s_ready, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rstmid_rel_ready", s_if.s_ready, 1'b1);
        chk("rstmid_rel_busy", busy, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("rstmid_quiet_tx[%0d]", k), tx, 1'b1);
            chk($sformatf("rstmid_quiet_busy[%0d]", k), busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
